trap_unit: RTL and testbench
============================

# trap_unit

Collects synchronous exceptions from the IF, ID and MEM pipeline stages and picks the architecturally oldest one. It presents that exception as a one-cycle trap request (cause plus faulting PC) to the CSR handler, which redirects to `mtvec`. It then drives a full-pipeline flush for a fixed number of cycles so that younger, squashed instructions cannot raise further traps. It sits upstream of the CSR handler and drives its `csr_trapID`, `csr_trapPC` and `flush` inputs.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: number of cycles `flush` is held at 2'b11 after a trap is taken; legal range 1–15.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: pipeline stall; gates IF/ID exception acceptance.
- `if_pc` in 32: PC of the instruction in IF.
- `if_misaligned` in 1: fetch target is not word-aligned (`if_pc[1:0] != 0`).
- `id_pc` in 32: PC of the instruction in ID.
- `id_illegal` in 1: ID decoded an illegal instruction.
- `id_ebreak` in 1: ID decoded EBREAK.
- `mem_pc` in 32: PC of the instruction in MEM.
- `mem_addr` in 32: data address in MEM.
- `mem_load_mis` in 1: misaligned load in MEM.
- `mem_store_mis` in 1: misaligned store in MEM.
- `trap_id` out 6: `[5]` is the trap-valid flag; `[4:0]` is the mcause code.
- `trap_pc` out 32: PC of the faulting instruction (this becomes `mepc`).
- `trap_tval` out 32: `mtval` value.
- `flush` out 2: 2'b11 means full flush; 2'b00 means none. No other encodings are driven.
- `busy` out 1: the unit is in the FLUSH state.
- `trap_count` out 32: number of traps taken, saturating.

## Operation
Cause codes (mcause):
- inst misaligned = 0, illegal = 2, breakpoint = 3, load misaligned = 4, store misaligned = 6.
- ECALL and MRET are excluded; the CSR handler decodes those directly.

Priority (oldest instruction first):
- MEM beats ID, which beats IF.
- Within MEM: load misaligned beats store misaligned.
- Within ID: illegal beats ebreak.

`stall` behaviour:
- While `stall` is 1, IF and ID exceptions are ignored; the instruction stays held and re-presents the exception later.
- MEM exceptions are always accepted.

FSM states: IDLE, FLUSH.
- IDLE, any accepted exception:
  - Register cause and PC.
  - Set `trap_tval`: `mem_addr` for MEM causes, `if_pc` for inst misaligned, 0 for illegal and ebreak.
  - Assert `trap_id[5]`, set `flush = 2'b11`, load the down-counter with `FLUSH_CYCLES-1`, go to FLUSH.
- FLUSH:
  - `flush = 2'b11`, `trap_id[5] = 0`, all exception inputs ignored.
  - Decrement the counter; when it is 0, go to IDLE.
- `trap_count` increments once per taken trap and holds at 0xFFFFFFFF.

## Timing
- All outputs are registered.
- Reset values: `trap_id = 0`, `trap_pc = 0`, `trap_tval = 0`, `flush = 2'b00`, `busy = 0`, `trap_count = 0`; state = IDLE.
- Latency: exception inputs sampled at edge N produce `trap_id[5] = 1` and `flush = 2'b11` during cycle N+1.
  - `trap_id[5]` is high for exactly one cycle.
  - `flush` stays high for exactly `FLUSH_CYCLES` cycles, N+1 through N+FLUSH_CYCLES.
  - `busy` mirrors `flush`.
- `trap_id[4:0]`, `trap_pc` and `trap_tval` hold their last value until the next trap.
- The earliest next trap is accepted at edge N+FLUSH_CYCLES, giving its pulse in cycle N+FLUSH_CYCLES+1.
- Simultaneous exceptions in several stages: only the highest-priority one is taken. The others belong to flushed instructions and are discarded.
- `rst` during FLUSH: the next cycle is IDLE with `flush = 0`. The in-flight trap is lost, but `trap_count` has already been incremented and is then cleared by reset.

## Structure
- Cause codes, the trap-valid bit index and the flush encodings go in the shared CSR definitions include, alongside the CSR op codes.
- One sub-module, `trap_prio_enc`: purely combinational priority encoder from the stage flags to {valid, stage, cause}.
- The FSM, counter and output registers live in `trap_unit`.

## Test plan
- Reset, then idle inputs: all outputs are 0 for 10 cycles.
- `id_illegal = 1`, `id_pc = 0x100`: next cycle `trap_id = 6'b100010`, `trap_pc = 0x100`, `trap_tval = 0`; `flush = 2'b11` for 2 cycles; `trap_count = 1`.
- `mem_store_mis` (`mem_pc = 0x200`, `mem_addr = 0x1003`) together with `id_illegal` (`id_pc = 0x208`) in the same cycle: `trap_id = 6'b100110`, `trap_pc = 0x200`, `trap_tval = 0x1003`; no second trap follows.
- `if_misaligned` with `stall = 1` for 3 cycles, then `stall = 0` with `if_pc = 0x302`: no trap while stalled, then `trap_id = 6'b100000`, `trap_tval = 0x302`.
- `FLUSH_CYCLES = 4`, `id_ebreak` re-asserted every cycle: exactly one trap pulse every 4 cycles, and `flush` stays continuously high.
- `rst` asserted in the second FLUSH cycle: the following cycle `flush = 0`, `busy = 0`, `trap_count = 0`.

Source files
------------

// File: rtl/trap_unit_pkg.sv
// Shared CSR definitions: CSR op codes, mcause codes, trap-valid bit index
// and flush encodings used by the trap unit and the CSR handler.
package trap_unit_pkg;

  typedef enum logic [1:0] {
    CSR_OP_NONE,
    CSR_OP_RW,
    CSR_OP_RS,
    CSR_OP_RC
  } csr_op_e;

  localparam logic [4:0] CAUSE_INST_MISALIGNED  = 5'd0;
  localparam logic [4:0] CAUSE_ILLEGAL          = 5'd2;
  localparam logic [4:0] CAUSE_BREAKPOINT       = 5'd3;
  localparam logic [4:0] CAUSE_LOAD_MISALIGNED  = 5'd4;
  localparam logic [4:0] CAUSE_STORE_MISALIGNED = 5'd6;

  localparam int unsigned TRAP_VALID_BIT = 5;

  localparam logic [1:0] FLUSH_NONE = 2'b00;
  localparam logic [1:0] FLUSH_ALL  = 2'b11;

  typedef enum logic [1:0] {
    STAGE_NONE,
    STAGE_IF,
    STAGE_ID,
    STAGE_MEM
  } trap_stage_e;

  typedef enum logic {
    ST_IDLE,
    ST_FLUSH
  } trap_state_e;

endpackage

// File: rtl/trap_unit_prio_enc.sv
// Combinational priority encoder: picks the oldest pending exception
// (MEM > ID > IF) and reports its stage and mcause code.
module trap_prio_enc
  import trap_unit_pkg::*;
(
  input  logic        mem_load_mis,
  input  logic        mem_store_mis,
  input  logic        id_illegal,
  input  logic        id_ebreak,
  input  logic        if_misaligned,
  output logic        valid,
  output trap_stage_e stage,
  output logic [4:0]  cause
);

  always_comb begin
    valid = 1'b0;
    stage = STAGE_NONE;
    cause = '0;
    if (mem_load_mis) begin
      valid = 1'b1;
      stage = STAGE_MEM;
      cause = CAUSE_LOAD_MISALIGNED;
    end else if (mem_store_mis) begin
      valid = 1'b1;
      stage = STAGE_MEM;
      cause = CAUSE_STORE_MISALIGNED;
    end else if (id_illegal) begin
      valid = 1'b1;
      stage = STAGE_ID;
      cause = CAUSE_ILLEGAL;
    end else if (id_ebreak) begin
      valid = 1'b1;
      stage = STAGE_ID;
      cause = CAUSE_BREAKPOINT;
    end else if (if_misaligned) begin
      valid = 1'b1;
      stage = STAGE_IF;
      cause = CAUSE_INST_MISALIGNED;
    end
  end

endmodule

// File: rtl/trap_unit.sv
// Trap unit: selects the oldest synchronous exception, issues a one-cycle
// trap request to the CSR handler and holds a full flush for FLUSH_CYCLES.
module trap_unit
  import trap_unit_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] if_pc,
  input  logic        if_misaligned,
  input  logic [31:0] id_pc,
  input  logic        id_illegal,
  input  logic        id_ebreak,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_addr,
  input  logic        mem_load_mis,
  input  logic        mem_store_mis,
  output logic [5:0]  trap_id,
  output logic [31:0] trap_pc,
  output logic [31:0] trap_tval,
  output logic [1:0]  flush,
  output logic        busy,
  output logic [31:0] trap_count
);

  logic        enc_valid;
  trap_stage_e enc_stage;
  logic [4:0]  enc_cause;

  trap_prio_enc u_prio_enc (
    .mem_load_mis  (mem_load_mis),
    .mem_store_mis (mem_store_mis),
    .id_illegal    (id_illegal    & ~stall),
    .id_ebreak     (id_ebreak     & ~stall),
    .if_misaligned (if_misaligned & ~stall),
    .valid         (enc_valid),
    .stage         (enc_stage),
    .cause         (enc_cause)
  );

  trap_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  trap_id_q, trap_id_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic [31:0] trap_tval_q, trap_tval_d;
  logic [1:0]  flush_q, flush_d;
  logic        busy_q, busy_d;
  logic [31:0] count_q, count_d;
  logic        take_trap;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    trap_id_d   = trap_id_q;
    trap_id_d[TRAP_VALID_BIT] = 1'b0;
    trap_pc_d   = trap_pc_q;
    trap_tval_d = trap_tval_q;
    flush_d     = flush_q;
    busy_d      = busy_q;
    count_d     = count_q;
    take_trap   = 1'b0;

    case (state_q)
      ST_IDLE: take_trap = enc_valid;
      ST_FLUSH: begin
        // Last flush cycle doubles as the accept slot, so back-to-back traps
        // keep flush continuously asserted.
        if (cnt_q == '0) begin
          state_d   = ST_IDLE;
          flush_d   = FLUSH_NONE;
          busy_d    = 1'b0;
          take_trap = enc_valid;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_trap) begin
      state_d   = ST_FLUSH;
      cnt_d     = 4'(FLUSH_CYCLES - 1);
      flush_d   = FLUSH_ALL;
      busy_d    = 1'b1;
      trap_id_d = {1'b1, enc_cause};
      case (enc_stage)
        STAGE_MEM: begin trap_pc_d = mem_pc; trap_tval_d = mem_addr; end
        STAGE_ID:  begin trap_pc_d = id_pc;  trap_tval_d = '0;       end
        default:   begin trap_pc_d = if_pc;  trap_tval_d = if_pc;    end
      endcase
      if (count_q != '1) count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      trap_id_q   <= '0;
      trap_pc_q   <= '0;
      trap_tval_q <= '0;
      flush_q     <= FLUSH_NONE;
      busy_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      trap_id_q   <= trap_id_d;
      trap_pc_q   <= trap_pc_d;
      trap_tval_q <= trap_tval_d;
      flush_q     <= flush_d;
      busy_q      <= busy_d;
      count_q     <= count_d;
    end
  end

  assign trap_id    = trap_id_q;
  assign trap_pc    = trap_pc_q;
  assign trap_tval  = trap_tval_q;
  assign flush      = flush_q;
  assign busy       = busy_q;
  assign trap_count = count_q;

endmodule

// File: tb/tb_trap_unit.sv
// Directed bench for trap_unit: default-depth instance plus a FLUSH_CYCLES=4
// instance sharing the same stimulus.
module tb_trap_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] if_pc = '0;
  logic        if_misaligned = 1'b0;
  logic [31:0] id_pc = '0;
  logic        id_illegal = 1'b0;
  logic        id_ebreak = 1'b0;
  logic [31:0] mem_pc = '0;
  logic [31:0] mem_addr = '0;
  logic        mem_load_mis = 1'b0;
  logic        mem_store_mis = 1'b0;

  logic [5:0]  trap_id_a,  trap_id_b;
  logic [31:0] trap_pc_a,  trap_pc_b;
  logic [31:0] trap_tval_a, trap_tval_b;
  logic [1:0]  flush_a,    flush_b;
  logic        busy_a,     busy_b;
  logic [31:0] count_a,    count_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  trap_unit dut_a (
    .clk(clk), .rst(rst), .stall(stall),
    .if_pc(if_pc), .if_misaligned(if_misaligned),
    .id_pc(id_pc), .id_illegal(id_illegal), .id_ebreak(id_ebreak),
    .mem_pc(mem_pc), .mem_addr(mem_addr),
    .mem_load_mis(mem_load_mis), .mem_store_mis(mem_store_mis),
    .trap_id(trap_id_a), .trap_pc(trap_pc_a), .trap_tval(trap_tval_a),
    .flush(flush_a), .busy(busy_a), .trap_count(count_a)
  );

  trap_unit #(.FLUSH_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .stall(stall),
    .if_pc(if_pc), .if_misaligned(if_misaligned),
    .id_pc(id_pc), .id_illegal(id_illegal), .id_ebreak(id_ebreak),
    .mem_pc(mem_pc), .mem_addr(mem_addr),
    .mem_load_mis(mem_load_mis), .mem_store_mis(mem_store_mis),
    .trap_id(trap_id_b), .trap_pc(trap_pc_b), .trap_tval(trap_tval_b),
    .flush(flush_b), .busy(busy_b), .trap_count(count_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; if_misaligned = 1'b0; id_illegal = 1'b0; id_ebreak = 1'b0;
    mem_load_mis = 1'b0; mem_store_mis = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    do_reset();

    // Idle after reset: everything zero.
    for (int i = 0; i < 10; i++) begin
      check("idle_trap_id", 32'(trap_id_a), 32'h0);
      check("idle_flush",   32'(flush_a),   32'h0);
      check("idle_busy",    32'(busy_a),    32'h0);
      check("idle_count",   count_a,        32'h0);
      check("idle_pc",      trap_pc_a,      32'h0);
      check("idle_tval",    trap_tval_a,    32'h0);
      tick();
    end

    // Illegal instruction in ID.
    id_illegal = 1'b1; id_pc = 32'h100;
    tick();
    clear_inputs();
    check("ill_trap_id", 32'(trap_id_a), 32'h22);
    check("ill_pc",      trap_pc_a,      32'h100);
    check("ill_tval",    trap_tval_a,    32'h0);
    check("ill_flush1",  32'(flush_a),   32'h3);
    check("ill_busy1",   32'(busy_a),    32'h1);
    check("ill_count",   count_a,        32'h1);
    tick();
    check("ill_trap_id2", 32'(trap_id_a), 32'h02);
    check("ill_flush2",   32'(flush_a),   32'h3);
    tick();
    check("ill_flush3", 32'(flush_a), 32'h0);
    check("ill_busy3",  32'(busy_a),  32'h0);

    // MEM store-misaligned beats simultaneous ID illegal.
    mem_store_mis = 1'b1; mem_pc = 32'h200; mem_addr = 32'h1003;
    id_illegal = 1'b1; id_pc = 32'h208;
    tick();
    clear_inputs();
    check("st_trap_id", 32'(trap_id_a), 32'h26);
    check("st_pc",      trap_pc_a,      32'h200);
    check("st_tval",    trap_tval_a,    32'h1003);
    check("st_count",   count_a,        32'h2);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("st_no_second", 32'(trap_id_a[5]), 32'h0);
    end
    check("st_hold_id",  32'(trap_id_a), 32'h06);
    check("st_count2",   count_a,        32'h2);

    // IF misaligned held off by stall, taken once stall drops.
    if_misaligned = 1'b1; if_pc = 32'h302; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_no_trap", 32'(trap_id_a[5]), 32'h0);
      check("stall_flush",   32'(flush_a),      32'h0);
    end
    stall = 1'b0;
    tick();
    clear_inputs();
    check("if_trap_id", 32'(trap_id_a), 32'h20);
    check("if_pc",      trap_pc_a,      32'h302);
    check("if_tval",    trap_tval_a,    32'h302);
    check("if_count",   count_a,        32'h3);
    tick();
    tick();

    // Load beats store; MEM accepted even under stall.
    stall = 1'b1; mem_load_mis = 1'b1; mem_store_mis = 1'b1;
    mem_pc = 32'h500; mem_addr = 32'h2001;
    tick();
    clear_inputs();
    check("ld_trap_id", 32'(trap_id_a), 32'h24);
    check("ld_pc",      trap_pc_a,      32'h500);
    check("ld_tval",    trap_tval_a,    32'h2001);
    tick();
    tick();

    // Illegal beats ebreak in ID.
    id_illegal = 1'b1; id_ebreak = 1'b1; id_pc = 32'h600;
    tick();
    clear_inputs();
    check("id_prio_trap_id", 32'(trap_id_a), 32'h22);
    tick();
    tick();

    // Ebreak alone.
    id_ebreak = 1'b1; id_pc = 32'h604;
    tick();
    clear_inputs();
    check("ebk_trap_id", 32'(trap_id_a), 32'h23);
    check("ebk_tval",    trap_tval_a,    32'h0);
    check("ebk_count",   count_a,        32'h6);
    tick();
    tick();

    // FLUSH_CYCLES=4 with ebreak held: one pulse every 4 cycles, flush steady.
    do_reset();
    id_ebreak = 1'b1; id_pc = 32'h400;
    tick();
    for (int i = 0; i < 12; i++) begin
      check("f4_pulse", 32'(trap_id_b[5]), ((i % 4) == 0) ? 32'h1 : 32'h0);
      check("f4_flush", 32'(flush_b),      32'h3);
      check("f4_busy",  32'(busy_b),       32'h1);
      tick();
    end
    clear_inputs();
    check("f4_count", count_b, 32'h4);
    check("f4_id",    32'(trap_id_b), 32'h23);

    // Reset during the second flush cycle.
    do_reset();
    id_illegal = 1'b1; id_pc = 32'h700;
    tick();
    clear_inputs();
    tick();
    check("rst_pre_flush", 32'(flush_a), 32'h3);
    check("rst_pre_count", count_a,      32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_flush",   32'(flush_a),   32'h0);
    check("rst_busy",    32'(busy_a),    32'h0);
    check("rst_count",   count_a,        32'h0);
    check("rst_trap_id", 32'(trap_id_a), 32'h0);
    tick();
    check("rst_after_flush", 32'(flush_a), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
